instr_fetch: RTL

- Instruction fetch unit. Owns the program counter and issues word fetches to instruction memory over a request/response interface.
- Buffers up to two fetched instructions with their PCs. Presents them to the decode stage (immediate generator, register file, control) through a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and discards stale fetches.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 106 ++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and the
// decode-side valid/ready handshake. The fetch unit takes the master side.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_ready;
   logic        misalign_err;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, pc, misalign_err,
      input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, pc, misalign_err,
      output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight and buffers up
// to two {instr, pc} entries for decode. Redirects flush and drop stale fetches.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst_n,
   instr_fetch_if.master bus
);

   typedef enum logic [2:0] {StBoot, StFetch, StWait, StFull, StDrop} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, req_pc_q, addr_q;
   logic        req_q, misalign_q;
   logic [1:0]  count_q, count_nxt;
   logic [31:0] instr0_q, pc0_q, instr1_q, pc1_q;

   logic        pop, redirect, accept;
   logic [31:0] target, fetch_base;

   always_comb begin
      pop        = (count_q != 2'd0) && bus.instr_ready && !bus.redirect_valid;
      redirect   = bus.redirect_valid && (state_q != StBoot);
      accept     = bus.imem_rvalid && (state_q == StWait) && !redirect;
      target     = {bus.redirect_pc[31:2], 2'b00};
      fetch_base = redirect ? target : fetch_pc_q;
      count_nxt  = count_q + {1'b0, accept} - {1'b0, pop};

      state_d = state_q;
      unique case (state_q)
         StBoot:  state_d = StFetch;
         // The request visible this cycle becomes stale on a redirect.
         StFetch: state_d = redirect ? StDrop : StWait;
         StWait: begin
            if (bus.imem_rvalid) begin
               if (redirect)                state_d = StFetch;
               else if (count_nxt == 2'd2)  state_d = StFull;
               else                         state_d = StFetch;
            end else if (redirect) begin
               state_d = StDrop;
            end
         end
         StFull:  if (redirect || pop) state_d = StFetch;
         StDrop:  if (bus.imem_rvalid) state_d = StFetch;
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StBoot;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'h0;
         addr_q     <= 32'h0;
         req_q      <= 1'b0;
         misalign_q <= 1'b0;
         count_q    <= 2'd0;
         instr0_q   <= 32'h0;
         pc0_q      <= 32'h0;
         instr1_q   <= 32'h0;
         pc1_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         misalign_q <= redirect && (bus.redirect_pc[1:0] != 2'b00);
         fetch_pc_q <= fetch_base;
         req_q      <= 1'b0;

         // The request is registered so it is high for the whole StFetch cycle.
         if (state_d == StFetch) begin
            req_q      <= 1'b1;
            addr_q     <= fetch_base;
            req_pc_q   <= fetch_base;
            fetch_pc_q <= fetch_base + 32'd4;
         end

         if (redirect) begin
            count_q <= 2'd0;
         end else begin
            count_q <= count_nxt;
            if (pop) begin
               instr0_q <= instr1_q;
               pc0_q    <= pc1_q;
            end
            // Push lands behind whatever survives this cycle's pop.
            if (accept) begin
               if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                  instr0_q <= bus.imem_rdata;
                  pc0_q    <= req_pc_q;
               end else begin
                  instr1_q <= bus.imem_rdata;
                  pc1_q    <= req_pc_q;
               end
            end
         end
      end
   end

   assign bus.imem_req     = req_q;
   assign bus.imem_addr    = addr_q;
   assign bus.instr_valid  = (count_q != 2'd0);
   assign bus.instr        = instr0_q;
   assign bus.pc           = pc0_q;
   assign bus.misalign_err = misalign_q;

endmodule
